// File: rtl/burst_mem_pkg.sv
// burst_mem_pkg: shared types and constants for burst_memory_responder.
//   bm_state_e    : responder FSM states
//   BM_BEATS      : beats per cacheline burst
//   BM_BEAT_W     : beat width in bits
//   BM_LINE_OFF   : address bit where the line index starts
//   BM_LFSR_SEED / BM_LFSR_TAPS : random-latency LFSR (used when
//                   BURST_MEM_RANDLAT_EN is defined)
package burst_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} bm_state_e;

  localparam int BM_BEATS    = 4;
  localparam int BM_BEAT_W   = 64;
  localparam int BM_LINE_OFF = 5;

  localparam logic [7:0] BM_LFSR_SEED = 8'hA5;
  // Fibonacci taps 8,6,5,4 -> state bits 7,5,4,3
  localparam logic [7:0] BM_LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] bm_lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & BM_LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/burst_mem_array.sv
// burst_mem_array: 4 beat banks of LINES x 64 bits.
//   clk            : clock
//   we/wbeat/widx/wdata : synchronous write port
//   rbeat/ridx     : read address, sampled at the clock edge
//   rdata          : registered read data for the address of the previous cycle
// Each bank is a plain simple-dual-port RAM with a registered output so it
// maps onto block RAM; the beat mux sits after the RAM registers.
module burst_mem_array
  import burst_mem_pkg::*;
#(
  parameter int LINES = 256,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [1:0]           wbeat,
  input  logic [IDX_W-1:0]     widx,
  input  logic [BM_BEAT_W-1:0] wdata,
  input  logic [1:0]           rbeat,
  input  logic [IDX_W-1:0]     ridx,
  output logic [BM_BEAT_W-1:0] rdata
);
  logic [BM_BEATS-1:0][BM_BEAT_W-1:0] rd_all;
  logic [1:0]                         rbeat_q;

  for (genvar b = 0; b < BM_BEATS; b++) begin : g_bank
    logic [BM_BEAT_W-1:0] mem [LINES];
    logic [BM_BEAT_W-1:0] rd_q;
    always_ff @(posedge clk) begin
      if (we && wbeat == 2'(b)) mem[widx] <= wdata;
      rd_q <= mem[ridx];
    end
    assign rd_all[b] = rd_q;
  end

  always_ff @(posedge clk) rbeat_q <= rbeat;

  assign rdata = rd_all[rbeat_q];
endmodule

// File: rtl/burst_memory_responder.sv
// burst_memory_responder: cacheline memory behind the 64-bit burst port.
// Accepts a read or write, waits LATENCY cycles, then moves 4 beats with
// mem_resp high on each; one DONE turnaround cycle follows every burst.
//   clk, reset_n          : clock, async active-low reset
//   mem_read, mem_write   : request (read wins when both high)
//   mem_addr              : byte address, line index at [5 +: log2(LINES)]
//   mem_wdata             : write beat, advanced by the initiator per mem_resp
//   mem_resp, mem_rdata   : registered beat strobe / read data (0 when idle)
// Optional feature macro: BURST_MEM_RANDLAT_EN adds 0..3 extra wait cycles
// drawn from an 8-bit LFSR stepped on every accepted request.
module burst_memory_responder
  import burst_mem_pkg::*;
#(
  parameter int LINES   = 256,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [63:0] mem_wdata,
  output logic        mem_resp,
  output logic [63:0] mem_rdata
);
  localparam int         IDX_W = $clog2(LINES);
  localparam logic [4:0] WLOAD = 5'(LATENCY - 1);

  bm_state_e         state_q, state_d;
  logic [IDX_W-1:0]  line_q,  line_d;
  logic              op_q,    op_d;     // 1 = read
  logic [4:0]        wcnt_q,  wcnt_d;
  logic [1:0]        beat_q,  beat_d;
  logic              resp_q,  resp_d;
  logic [4:0]        extra;
  logic [63:0]       arr_rdata;
  logic              unused_addr;

  assign unused_addr = ^{mem_addr[31:BM_LINE_OFF+IDX_W], mem_addr[BM_LINE_OFF-1:0]};

`ifdef BURST_MEM_RANDLAT_EN
  logic [7:0] lfsr_q, lfsr_d;
  assign extra = {3'b000, lfsr_q[1:0]};
`else
  assign extra = 5'd0;
`endif

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    op_d    = op_q;
    wcnt_d  = wcnt_q;
    beat_d  = beat_q;
    resp_d  = 1'b0;
`ifdef BURST_MEM_RANDLAT_EN
    lfsr_d  = lfsr_q;
`endif
    case (state_q)
      IDLE: if (mem_read | mem_write) begin
        line_d  = mem_addr[BM_LINE_OFF +: IDX_W];
        op_d    = mem_read;
        wcnt_d  = WLOAD + extra;
        state_d = WAIT;
`ifdef BURST_MEM_RANDLAT_EN
        lfsr_d  = bm_lfsr_next(lfsr_q);
`endif
      end
      WAIT: begin
        if (wcnt_q == 5'd0) begin
          state_d = BURST;
          beat_d  = 2'd0;
          resp_d  = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 5'd1;
        end
      end
      BURST: begin
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) state_d = DONE;
        else                resp_d  = 1'b1;
      end
      DONE:    state_d = IDLE;   // request ignored here by design
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      line_q  <= '0;
      op_q    <= 1'b0;
      wcnt_q  <= 5'd0;
      beat_q  <= 2'd0;
      resp_q  <= 1'b0;
`ifdef BURST_MEM_RANDLAT_EN
      lfsr_q  <= BM_LFSR_SEED;
`endif
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      op_q    <= op_d;
      wcnt_q  <= wcnt_d;
      beat_q  <= beat_d;
      resp_q  <= resp_d;
`ifdef BURST_MEM_RANDLAT_EN
      lfsr_q  <= lfsr_d;
`endif
    end
  end

  // Read address runs one beat ahead: the last WAIT cycle fetches beat 0,
  // BURST beat k fetches beat k+1, so the RAM output register lines up
  // with mem_resp.
  burst_mem_array #(.LINES(LINES), .IDX_W(IDX_W)) u_array (
    .clk   (clk),
    .we    (state_q == BURST && !op_q),
    .wbeat (beat_q),
    .widx  (line_q),
    .wdata (mem_wdata),
    .rbeat ((state_q == BURST) ? beat_q + 2'd1 : 2'd0),
    .ridx  (line_q),
    .rdata (arr_rdata)
  );

  assign mem_resp  = resp_q;
  assign mem_rdata = (resp_q && op_q) ? arr_rdata : 64'd0;
endmodule

// File: doc/burst_memory_responder.md
# burst_memory_responder

Synthesizable physical-memory responder for the 64-bit burst side of the cacheline adaptor: accepts a cacheline read or write, waits a configurable latency, then transfers four 64-bit beats with a per-beat response strobe. It sits where external memory connects to the core's `mem_*` ports. It provides a self-contained backing store for FPGA bring-up and for cache, arbiter and adaptor regression without a behavioural memory model.

## Interface
Parameters:
- `LINES`, 256: number of 256-bit cachelines stored; power of two, ≥ 2.
- `LATENCY`, 4: wait cycles between request acceptance and the first beat; range 1..15.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `mem_read` in 1: burst read request, held by the initiator until the last beat.
- `mem_write` in 1: burst write request, held by the initiator until the last beat.
- `mem_addr` in 32: byte address; bits [4:0] ignored.
- `mem_wdata` in 64: write beat; the initiator advances it after each `mem_resp` cycle.
- `mem_resp` out 1: beat strobe, high for exactly 4 consecutive cycles per burst.
- `mem_rdata` out 64: read beat, valid while `mem_resp` is high.

## Operation
- Storage is 4 beat banks of `LINES` × 64 bits. Beat k holds bits [64k+63:64k] of the line. Line index is `mem_addr[5 +: $clog2(LINES)]`. Upper address bits alias (wrap-around).
- Storage is not cleared by reset. Contents are undefined until written.
- FSM states: IDLE, WAIT, BURST, DONE.
- IDLE: when `mem_read | mem_write`, latch the line index, latch `op = mem_read` (read wins if both are high), load `wcnt = LATENCY-1`, and go to WAIT.
- WAIT: decrement `wcnt`. When `wcnt == 0`, go to BURST with `beat = 0`.
- BURST: `mem_resp = 1`.
  - Read: `mem_rdata` is bank[beat][line].
  - Write: `mem_wdata` is written into bank[beat][line] at the edge ending the cycle.
  - `beat` increments each cycle. After beat 3, go to DONE.
- DONE: one turnaround cycle with `mem_resp = 0`. Requests are ignored in this cycle, then the FSM returns to IDLE.
- Address and op are fixed at acceptance. Changes to `mem_addr`, `mem_read` or `mem_write` mid-burst are ignored.
- If the request is dropped before beat 3, the burst still completes all 4 beats. For writes, whatever `mem_wdata` is present is committed.
- Back-to-back requests: a request still held in DONE is not re-accepted. A request present in the following IDLE cycle is accepted.

## Timing
- Reset values: `mem_resp = 0`, `mem_rdata = 0`, state IDLE, `wcnt = 0`, `beat = 0`. Reset takes effect immediately, including mid-burst; the partial burst is abandoned and any beats already written remain written.
- `mem_resp` and `mem_rdata` are registered outputs. `mem_rdata` is 0 whenever `mem_resp` is low.
- Request first high in cycle c0 → `mem_resp` high in cycles c0+LATENCY+1 through c0+LATENCY+4 → DONE in c0+LATENCY+5 → earliest next acceptance in c0+LATENCY+6.
- Occupancy is LATENCY+6 cycles per burst.
- Read-after-write to the same line in the next burst returns the new data; no hazard window.

## Configuration
- `BURST_MEM_RANDLAT_EN` defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 on reset) advances once per accepted request.
  - WAIT length is LATENCY + `lfsr[1:0]` (LATENCY..LATENCY+3 cycles).
  - All other timing is unchanged.
- Not defined: no LFSR is present and WAIT is exactly LATENCY cycles.

## Structure
- Package `burst_mem_pkg` contains:
  - state enum `bm_state_e` (IDLE, WAIT, BURST, DONE);
  - `BM_BEATS = 4`, `BM_BEAT_W = 64`, `BM_LINE_OFF = 5`;
  - the LFSR seed and tap constant.
- One sub-module, `burst_mem_array`: 4 × `LINES` × 64 storage with one synchronous write port (beat select, index, data, enable) and one read port (beat select, index). It is inferable as block RAM; the read address is presented one cycle ahead so that `mem_rdata` stays registered.

## Test plan
- Reset, then write line addr 32'h0000_0040 with beats 64'h1111…, 2222…, 3333…, 4444…; read it back → read `mem_resp` high exactly cycles c0+5..c0+8 (LATENCY=4) with beats returned in order 1111…, 2222…, 3333…, 4444….
- Aliasing: write 32'h0000_2040 (LINES=256) with data D, then read 32'h0000_0040 → D returned; address bits [4:0]=5'h1F are ignored.
- Simultaneous `mem_read` and `mem_write` on a line holding D → read performed, D returned, storage unchanged.
- Assert `reset_n` low during beat 2 of a write → `mem_resp` and `mem_rdata` 0 immediately; a later read shows beats 0–1 new and beats 2–3 old.
- Request held continuously across two bursts → DONE gap with `mem_resp = 0` for 1 cycle; the second burst starts LATENCY+6 cycles after the first acceptance.
- With `BURST_MEM_RANDLAT_EN`: 16 reads → every start latency lies in LATENCY+1..LATENCY+4, and the sequence matches the LFSR model seeded 8'hA5.
